// File: rtl/audio_gain.sv
// Stereo volume stage: pops an L/R pair, multiplies by GAIN, dequantizes, rescales and pushes the pair.
// Optional output clamping is enabled with `define AUDIO_GAIN_SATURATE_EN (default: wrap-around).
module audio_gain #(
   parameter int                           DATA_SIZE  = 32,
   parameter logic signed [DATA_SIZE-1:0]  GAIN       = 'h400,
   parameter int                           QUANT_BITS = 10,
   parameter int                           OUT_SHIFT  = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic signed [DATA_SIZE-1:0]   left_in,
   input  logic                          left_empty,
   output logic                          left_rd_en,
   input  logic signed [DATA_SIZE-1:0]   right_in,
   input  logic                          right_empty,
   output logic                          right_rd_en,
   output logic signed [DATA_SIZE-1:0]   left_out,
   input  logic                          left_full,
   output logic                          left_wr_en,
   output logic signed [DATA_SIZE-1:0]   right_out,
   input  logic                          right_full,
   output logic                          right_wr_en
);

   localparam int PROD_W  = 2 * DATA_SIZE;
   localparam int SCALE_W = PROD_W + OUT_SHIFT;

   localparam logic signed [PROD_W-1:0] GAIN_EXT = PROD_W'(GAIN);

`ifdef AUDIO_GAIN_SATURATE_EN
   localparam logic signed [SCALE_W-1:0] SAT_MAX =
      {{(SCALE_W-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
   localparam logic signed [SCALE_W-1:0] SAT_MIN =
      {{(SCALE_W-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};
`endif

   typedef enum logic [1:0] {
      S_READ  = 2'd0,
      S_MULT  = 2'd1,
      S_SCALE = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   state_t state, next_state;

   logic signed [DATA_SIZE-1:0] left_p0, right_p0;
   logic signed [PROD_W-1:0]    left_p1, right_p1;
   logic signed [DATA_SIZE-1:0] left_p2, right_p2;

   logic pop, push;

   // Arithmetic right shift floors toward -inf before the output left shift.
   function automatic logic signed [SCALE_W-1:0] scale(input logic signed [PROD_W-1:0] p);
      logic signed [SCALE_W-1:0] q;
      q = SCALE_W'(p >>> QUANT_BITS);
      return q <<< OUT_SHIFT;
   endfunction

   function automatic logic signed [DATA_SIZE-1:0] to_out(input logic signed [SCALE_W-1:0] s);
`ifdef AUDIO_GAIN_SATURATE_EN
      if (s > SAT_MAX)
         return {1'b0, {(DATA_SIZE-1){1'b1}}};
      else if (s < SAT_MIN)
         return {1'b1, {(DATA_SIZE-1){1'b0}}};
      else
         return s[DATA_SIZE-1:0];
`else
      return s[DATA_SIZE-1:0];
`endif
   endfunction

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state <= S_READ;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_READ:  if (pop) next_state = S_MULT;
         S_MULT:  next_state = S_SCALE;
         S_SCALE: next_state = S_WRITE;
         S_WRITE: if (push) next_state = S_READ;
         default: next_state = S_READ;
      endcase
   end

   // Handshakes are gated by reset so they drop the moment reset asserts.
   always_comb begin
      pop  = reset && (state == S_READ)  && !left_empty && !right_empty;
      push = reset && (state == S_WRITE) && !left_full  && !right_full;
      left_rd_en  = pop;
      right_rd_en = pop;
      left_wr_en  = push;
      right_wr_en = push;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         left_p0  <= '0;
         right_p0 <= '0;
         left_p1  <= '0;
         right_p1 <= '0;
         left_p2  <= '0;
         right_p2 <= '0;
      end else begin
         // p0: captured input pair
         if (pop) begin
            left_p0  <= left_in;
            right_p0 <= right_in;
         end
         // p1: full-width products
         if (state == S_MULT) begin
            left_p1  <= PROD_W'(left_p0)  * GAIN_EXT;
            right_p1 <= PROD_W'(right_p0) * GAIN_EXT;
         end
         // p2: scaled output samples, held through any back-pressure stall
         if (state == S_SCALE) begin
            left_p2  <= to_out(scale(left_p1));
            right_p2 <= to_out(scale(right_p1));
         end
      end
   end

   assign left_out  = left_p2;
   assign right_out = right_p2;

endmodule

// File: tb/tb_audio_gain.sv
// Directed bench for audio_gain: unity-gain and 1.5-gain instances share stimulus and FIFO flags.
module tb_audio_gain;

   logic               clock;
   logic               reset;
   logic signed [31:0] left_in, right_in;
   logic               left_empty, right_empty, left_full, right_full;
   logic               left_rd_en, right_rd_en, left_wr_en, right_wr_en;
   logic signed [31:0] left_out, right_out;
   logic               g_left_rd_en, g_right_rd_en, g_left_wr_en, g_right_wr_en;
   logic signed [31:0] g_left_out, g_right_out;

   int checks   = 0;
   int failures = 0;

   audio_gain dut (
      .clock(clock), .reset(reset),
      .left_in(left_in), .left_empty(left_empty), .left_rd_en(left_rd_en),
      .right_in(right_in), .right_empty(right_empty), .right_rd_en(right_rd_en),
      .left_out(left_out), .left_full(left_full), .left_wr_en(left_wr_en),
      .right_out(right_out), .right_full(right_full), .right_wr_en(right_wr_en)
   );

   audio_gain #(.GAIN(32'sd1536)) dut_g (
      .clock(clock), .reset(reset),
      .left_in(left_in), .left_empty(left_empty), .left_rd_en(g_left_rd_en),
      .right_in(right_in), .right_empty(right_empty), .right_rd_en(g_right_rd_en),
      .left_out(g_left_out), .left_full(left_full), .left_wr_en(g_left_wr_en),
      .right_out(g_right_out), .right_full(right_full), .right_wr_en(g_right_wr_en)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Pops one pair and waits (bounded) for the joint push; leaves time inside the S_WRITE cycle.
   task automatic push_pair(input logic signed [31:0] l, input logic signed [31:0] r,
                            output logic saw_rd, output int lat);
      left_in = l;
      right_in = r;
      left_empty = 1'b0;
      right_empty = 1'b0;
      #1;
      saw_rd = left_rd_en && right_rd_en;
      tick;
      left_empty = 1'b1;
      right_empty = 1'b1;
      #1;
      lat = 1;
      while (!(left_wr_en && right_wr_en) && lat < 10) begin
         tick;
         lat++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      left_in = 32'sd55;
      right_in = 32'sd66;
      left_empty = 1'b0;
      right_empty = 1'b0;
      left_full = 1'b0;
      right_full = 1'b0;
      tick;
      tick;
      checks++; if (left_rd_en !== 1'b0 || right_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got %b%b want 00", left_rd_en, right_rd_en); end
      checks++; if (left_wr_en !== 1'b0 || right_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got %b%b want 00", left_wr_en, right_wr_en); end
      checks++; if (left_out !== 32'sd0) begin failures++; $display("FAIL reset_left_out got %0d want 0", left_out); end
      checks++; if (right_out !== 32'sd0) begin failures++; $display("FAIL reset_right_out got %0d want 0", right_out); end
      left_empty = 1'b1;
      right_empty = 1'b1;
      reset = 1'b1;
      tick;
      checks++; if (left_rd_en !== 1'b0 || left_wr_en !== 1'b0) begin failures++; $display("FAIL idle_enables got rd=%b wr=%b want 0 0", left_rd_en, left_wr_en); end
   endtask

   task automatic test_unity;
      logic saw;
      int lat;
      push_pair(32'sd100, -32'sd3, saw, lat);
      checks++; if (saw !== 1'b1) begin failures++; $display("FAIL unity_pop got %b want 1", saw); end
      checks++; if (lat != 3) begin failures++; $display("FAIL unity_latency got %0d want 3", lat); end
      checks++; if (left_out !== 32'sd1600) begin failures++; $display("FAIL unity_left got %0d want 1600", left_out); end
      checks++; if (right_out !== -32'sd48) begin failures++; $display("FAIL unity_right got %0d want -48", right_out); end
      tick;
      checks++; if (left_wr_en !== 1'b0 || right_wr_en !== 1'b0) begin failures++; $display("FAIL unity_single_push got %b%b want 00", left_wr_en, right_wr_en); end
   endtask

   task automatic test_gain;
      logic saw;
      int lat;
      push_pair(-32'sd3, 32'sd7, saw, lat);
      checks++; if (g_left_wr_en !== 1'b1 || g_right_wr_en !== 1'b1) begin failures++; $display("FAIL gain_push got %b%b want 11", g_left_wr_en, g_right_wr_en); end
      checks++; if (g_left_out !== -32'sd80) begin failures++; $display("FAIL gain_left got %0d want -80", g_left_out); end
      checks++; if (g_right_out !== 32'sd160) begin failures++; $display("FAIL gain_right got %0d want 160", g_right_out); end
      checks++; if (right_out !== 32'sd112) begin failures++; $display("FAIL gain_unity_right got %0d want 112", right_out); end
      tick;
   endtask

   task automatic test_overflow;
      logic saw;
      int lat;
      logic signed [31:0] exp_l, exp_r;
`ifdef AUDIO_GAIN_SATURATE_EN
      exp_l = 32'sh7FFFFFFF;
      exp_r = 32'sh80000000;
`else
      exp_l = 32'sh0;
      exp_r = 32'sh0;
`endif
      push_pair(32'sh10000000, 32'shF0000000, saw, lat);
      checks++; if (left_out !== exp_l) begin failures++; $display("FAIL overflow_left got %h want %h", left_out, exp_l); end
      checks++; if (right_out !== exp_r) begin failures++; $display("FAIL overflow_right got %h want %h", right_out, exp_r); end
      tick;
   endtask

   task automatic test_one_empty;
      logic saw;
      int lat;
      left_in = 32'sd5;
      left_empty = 1'b0;
      right_empty = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++; if (left_rd_en !== 1'b0 || right_rd_en !== 1'b0) begin failures++; $display("FAIL one_empty_pop cycle %0d got %b%b want 00", i, left_rd_en, right_rd_en); end
         tick;
      end
      push_pair(32'sd5, -32'sd1, saw, lat);
      checks++; if (saw !== 1'b1) begin failures++; $display("FAIL one_empty_joint_pop got %b want 1", saw); end
      checks++; if (left_out !== 32'sd80 || right_out !== -32'sd16) begin failures++; $display("FAIL one_empty_data got %0d,%0d want 80,-16", left_out, right_out); end
      tick;
   endtask

   task automatic test_back_pressure;
      right_full = 1'b1;
      left_in = 32'sd9;
      right_in = -32'sd2;
      left_empty = 1'b0;
      right_empty = 1'b0;
      tick;
      left_empty = 1'b1;
      right_empty = 1'b1;
      tick;
      tick;
      left_in = 32'sd77;
      right_in = 32'sd77;
      left_empty = 1'b0;
      right_empty = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #1;
         checks++; if (left_wr_en !== 1'b0 || right_wr_en !== 1'b0 || left_rd_en !== 1'b0 || right_rd_en !== 1'b0) begin
            failures++; $display("FAIL stall_enables cycle %0d got wr=%b%b rd=%b%b want 0000", i, left_wr_en, right_wr_en, left_rd_en, right_rd_en); end
         checks++; if (left_out !== 32'sd144 || right_out !== -32'sd32) begin failures++; $display("FAIL stall_data cycle %0d got %0d,%0d want 144,-32", i, left_out, right_out); end
         tick;
      end
      right_full = 1'b0;
      #1;
      checks++; if (left_wr_en !== 1'b1 || right_wr_en !== 1'b1) begin failures++; $display("FAIL release_push got %b%b want 11", left_wr_en, right_wr_en); end
      left_empty = 1'b1;
      right_empty = 1'b1;
      tick;
      checks++; if (left_wr_en !== 1'b0 || right_wr_en !== 1'b0) begin failures++; $display("FAIL release_single got %b%b want 00", left_wr_en, right_wr_en); end
   endtask

   task automatic test_reset_mid;
      logic saw;
      int lat;
      left_in = 32'sd11;
      right_in = 32'sd12;
      left_empty = 1'b0;
      right_empty = 1'b0;
      tick;
      left_empty = 1'b1;
      right_empty = 1'b1;
      tick;
      reset = 1'b0;
      #1;
      checks++; if (left_out !== 32'sd0 || right_out !== 32'sd0) begin failures++; $display("FAIL midreset_data got %0d,%0d want 0,0", left_out, right_out); end
      checks++; if (left_wr_en !== 1'b0 || right_wr_en !== 1'b0 || left_rd_en !== 1'b0) begin failures++; $display("FAIL midreset_enables got wr=%b%b rd=%b want 000", left_wr_en, right_wr_en, left_rd_en); end
      tick;
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick;
         checks++; if (left_wr_en !== 1'b0 || right_wr_en !== 1'b0) begin failures++; $display("FAIL midreset_ghost_write cycle %0d got %b%b want 00", i, left_wr_en, right_wr_en); end
      end
      push_pair(32'sd2, 32'sd3, saw, lat);
      checks++; if (lat != 3) begin failures++; $display("FAIL after_reset_latency got %0d want 3", lat); end
      checks++; if (left_out !== 32'sd32 || right_out !== 32'sd48) begin failures++; $display("FAIL after_reset_data got %0d,%0d want 32,48", left_out, right_out); end
      tick;
   endtask

   initial begin
      test_reset;
      test_unity;
      test_gain;
      test_overflow;
      test_one_empty;
      test_back_pressure;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
